// File: rtl/xdcr_out_guard_pkg.sv
// Shared types for the transducer output guard: controller state encoding
// and the width of the tripping-channel index.
package xdcr_out_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam int FAULT_CH_W = 8;

endpackage

// File: rtl/xdcr_out_guard_if.sv
// Controller-facing bundle of the output guard: enables and PWM in,
// gated drive and fault reporting out.
interface xdcr_out_guard_if #(
  parameter int TRANS_NUM = 249,
  parameter int CNT_WIDTH = 16
);
  import xdcr_out_guard_pkg::*;

  logic                  ENABLE;
  logic [CNT_WIDTH-1:0]  MAX_HIGH;
  logic                  FAULT_CLR;
  logic [TRANS_NUM-1:0]  PWM_IN;
  logic [TRANS_NUM-1:0]  XDCR_OUT;
  logic                  FAULT;
  logic [FAULT_CH_W-1:0] FAULT_CH;
  logic                  FAULT_PULSE;
  logic [1:0]            STATE;

  modport master (
    output ENABLE, MAX_HIGH, FAULT_CLR, PWM_IN,
    input  XDCR_OUT, FAULT, FAULT_CH, FAULT_PULSE, STATE
  );

  modport slave (
    input  ENABLE, MAX_HIGH, FAULT_CLR, PWM_IN,
    output XDCR_OUT, FAULT, FAULT_CH, FAULT_PULSE, STATE
  );

endinterface

// File: rtl/xdcr_high_watchdog.sv
// One channel's consecutive-high counter and trip compare. The trip is
// combinational so a new MAX_HIGH is honoured from the cycle it arrives.
module xdcr_high_watchdog #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pwm,
  input  logic [CNT_WIDTH-1:0] i_max_high,
  output logic                 o_trip
);

  logic [CNT_WIDTH-1:0] r_cnt;

  // NOTE: the reset is sampled on the clock edge like any other input, and
  // all sequential state uses non-blocking assignment so every register
  // updates from pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_pwm) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_trip = i_pwm && (i_max_high != '0) && (r_cnt == i_max_high);

endmodule

// File: rtl/xdcr_out_guard.sv
// Gates per-channel PWM to the transducers behind an IDLE/ARM/RUN/FAULT
// controller and latches the lowest channel that overstays its high time.
module xdcr_out_guard
  import xdcr_out_guard_pkg::*;
#(
  parameter int TRANS_NUM = 249,
  parameter int CNT_WIDTH = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  xdcr_out_guard_if.slave   bus
);

  state_e                r_state;
  logic [TRANS_NUM-1:0]  r_xdcr;
  logic                  r_fault;
  logic [FAULT_CH_W-1:0] r_fault_ch;
  logic                  r_fault_pulse;

  logic [TRANS_NUM-1:0]  w_trip;
  logic                  w_any_trip;
  logic [FAULT_CH_W-1:0] w_trip_idx;

  for (genvar gi = 0; gi < TRANS_NUM; gi++) begin : g_wd
    xdcr_high_watchdog #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_wd (
      .i_clk      (CLK),
      .i_rst_n    (RESET_N),
      .i_pwm      (bus.PWM_IN[gi]),
      .i_max_high (bus.MAX_HIGH),
      .o_trip     (w_trip[gi])
    );
  end

  // Scanning downward leaves the lowest tripping index as the final value.
  always_comb begin
    w_trip_idx = '0;
    for (int i = TRANS_NUM - 1; i >= 0; i--) begin
      if (w_trip[i]) w_trip_idx = FAULT_CH_W'(i);
    end
  end

  assign w_any_trip = |w_trip;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state       <= ST_IDLE;
      r_xdcr        <= '0;
      r_fault       <= 1'b0;
      r_fault_ch    <= '0;
      r_fault_pulse <= 1'b0;
    end else begin
      r_xdcr        <= (r_state == ST_RUN) ? bus.PWM_IN : '0;
      r_fault_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.ENABLE) r_state <= ST_ARM;
        end
        ST_ARM: begin
          // Wait for a low phase so the first emitted pulse is whole.
          if (!bus.ENABLE)             r_state <= ST_IDLE;
          else if (bus.PWM_IN == '0)   r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_any_trip) begin
            r_state       <= ST_FAULT;
            r_fault       <= 1'b1;
            r_fault_pulse <= 1'b1;
            r_fault_ch    <= w_trip_idx;
          end else if (!bus.ENABLE) begin
            r_state <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          // A clear that collides with a fresh trip is refused but re-indexed.
          if (bus.FAULT_CLR) begin
            if (w_any_trip) begin
              r_fault_ch <= w_trip_idx;
            end else begin
              r_state    <= bus.ENABLE ? ST_ARM : ST_IDLE;
              r_fault    <= 1'b0;
              r_fault_ch <= '0;
            end
          end
        end
      endcase
    end
  end

  assign bus.XDCR_OUT    = r_xdcr;
  assign bus.FAULT       = r_fault;
  assign bus.FAULT_CH    = r_fault_ch;
  assign bus.FAULT_PULSE = r_fault_pulse;
  assign bus.STATE       = r_state;

endmodule

// File: tb/tb_xdcr_out_guard.sv
// Directed bench for xdcr_out_guard: stimulus queues expected values tagged
// with the edge after which they must hold; a negedge monitor pops and compares.
module tb_xdcr_out_guard;
  import xdcr_out_guard_pkg::*;

  localparam int TN = 249;
  localparam int CW = 16;

  typedef enum {K_STATE, K_FAULT, K_PULSE, K_CH, K_XOUT} kind_e;

  typedef struct {
    int              cyc;
    kind_e           kind;
    logic [TN-1:0]   val;
    string           name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  xdcr_out_guard_if #(.TRANS_NUM(TN), .CNT_WIDTH(CW)) bus ();

  xdcr_out_guard #(
    .TRANS_NUM (TN),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic logic [TN-1:0] bit_v(int i);
    logic [TN-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [TN-1:0] sv(int v);
    logic [TN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [TN-1:0] actual(kind_e k);
    logic [TN-1:0] r;
    r = '0;
    case (k)
      K_STATE: r[1:0] = bus.STATE;
      K_FAULT: r[0]   = bus.FAULT;
      K_PULSE: r[0]   = bus.FAULT_PULSE;
      K_CH:    r[7:0] = bus.FAULT_CH;
      K_XOUT:  r      = bus.XDCR_OUT;
    endcase
    return r;
  endfunction

  task automatic check(string nm, logic [TN-1:0] act, logic [TN-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", nm, edge_cnt, act, req);
    end
  endtask

  task automatic expect_at(int dly, kind_e k, logic [TN-1:0] v, string nm);
    exp_t e;
    e.cyc  = edge_cnt + dly;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: outputs are registered, so the negedge view is stable.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc <= edge_cnt) begin
          check(exp_q[i].name, actual(exp_q[i].kind), exp_q[i].val);
          exp_q.delete(i);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.ENABLE    = 1'b0;
    bus.MAX_HIGH  = '0;
    bus.FAULT_CLR = 1'b0;
    bus.PWM_IN    = '0;

    // Reset state
    step(1);
    expect_at(1, K_STATE, sv(ST_IDLE), "rst_state");
    expect_at(1, K_FAULT, sv(0), "rst_fault");
    expect_at(1, K_PULSE, sv(0), "rst_pulse");
    expect_at(1, K_CH,    sv(0), "rst_ch");
    expect_at(1, K_XOUT,  '0,    "rst_xout");
    step(1);

    // Enable with ch0 high: hold in ARM until PWM all low, then RUN
    rst_n      = 1'b1;
    bus.ENABLE = 1'b1;
    bus.PWM_IN = bit_v(0);
    expect_at(1, K_STATE, sv(ST_ARM), "arm_enter");
    expect_at(3, K_STATE, sv(ST_ARM), "arm_hold");
    expect_at(3, K_XOUT,  '0,         "arm_xout_off");
    step(3);
    bus.PWM_IN = '0;
    expect_at(1, K_STATE, sv(ST_RUN), "run_enter");
    step(1);
    bus.PWM_IN = bit_v(0);
    expect_at(1, K_XOUT, bit_v(0), "run_follow_hi");
    step(1);
    bus.PWM_IN = '0;
    expect_at(1, K_XOUT, '0, "run_follow_lo");
    step(1);
    bus.PWM_IN = bit_v(0);
    expect_at(1, K_XOUT, bit_v(0), "run_follow_hi2");
    step(1);
    bus.PWM_IN = '0;
    step(1);

    // ch5 overstays MAX_HIGH=100
    bus.MAX_HIGH = CW'(100);
    bus.PWM_IN   = bit_v(5);
    expect_at(50,  K_XOUT,  bit_v(5),   "ch5_passing");
    expect_at(100, K_FAULT, sv(0),      "ch5_no_early_trip");
    expect_at(101, K_FAULT, sv(1),      "ch5_fault");
    expect_at(101, K_STATE, sv(ST_FAULT), "ch5_state");
    expect_at(101, K_CH,    sv(5),      "ch5_idx");
    expect_at(101, K_PULSE, sv(1),      "ch5_pulse_hi");
    expect_at(102, K_PULSE, sv(0),      "ch5_pulse_lo");
    expect_at(102, K_XOUT,  '0,         "ch5_xout_off");
    step(102);

    // ENABLE alone cannot leave FAULT
    bus.PWM_IN = '0;
    bus.ENABLE = 1'b0;
    expect_at(2, K_STATE, sv(ST_FAULT), "fault_sticky");
    expect_at(2, K_CH,    sv(5),        "fault_ch_held");
    step(2);

    // Clear colliding with a ch3 trip: stays FAULT, index moves to 3
    bus.ENABLE = 1'b1;
    bus.PWM_IN = bit_v(3);
    expect_at(50, K_STATE, sv(ST_FAULT), "fault_hold_wait");
    step(100);
    bus.FAULT_CLR = 1'b1;
    expect_at(1, K_STATE, sv(ST_FAULT), "clr_trip_state");
    expect_at(1, K_CH,    sv(3),        "clr_trip_idx");
    expect_at(1, K_PULSE, sv(0),        "clr_trip_no_pulse");
    step(1);
    bus.FAULT_CLR = 1'b0;
    bus.PWM_IN    = '0;
    step(1);
    bus.FAULT_CLR = 1'b1;
    expect_at(1, K_STATE, sv(ST_ARM), "clr_to_arm");
    expect_at(1, K_FAULT, sv(0),      "clr_fault_low");
    step(1);
    bus.FAULT_CLR = 1'b0;
    expect_at(1, K_STATE, sv(ST_RUN), "rearm_run");
    step(1);

    // ch7 and ch200 trip together: lowest index wins
    bus.PWM_IN = bit_v(7) | bit_v(200);
    expect_at(100, K_STATE, sv(ST_RUN),   "dual_pre");
    expect_at(101, K_STATE, sv(ST_FAULT), "dual_state");
    expect_at(101, K_CH,    sv(7),        "dual_idx");
    expect_at(101, K_PULSE, sv(1),        "dual_pulse");
    expect_at(102, K_XOUT,  '0,           "dual_xout_off");
    step(102);
    bus.PWM_IN = '0;
    step(1);
    bus.FAULT_CLR = 1'b1;
    expect_at(1, K_STATE, sv(ST_ARM), "dual_clr");
    step(1);
    bus.FAULT_CLR = 1'b0;
    expect_at(1, K_STATE, sv(ST_RUN), "dual_rearm");
    step(1);

    // MAX_HIGH=0 disables; raising it mid-pulse takes effect at once
    bus.MAX_HIGH = '0;
    bus.PWM_IN   = bit_v(10);
    expect_at(30, K_STATE, sv(ST_RUN), "wd_disabled");
    step(30);
    bus.MAX_HIGH = CW'(40);
    expect_at(10, K_STATE, sv(ST_RUN),   "newmax_pre");
    expect_at(11, K_STATE, sv(ST_FAULT), "newmax_trip");
    expect_at(11, K_CH,    sv(10),       "newmax_idx");
    step(11);

    // Reset mid-FAULT discards the latched fault
    rst_n = 1'b0;
    expect_at(1, K_FAULT, sv(0),       "rstf_fault");
    expect_at(1, K_STATE, sv(ST_IDLE), "rstf_state");
    expect_at(1, K_CH,    sv(0),       "rstf_ch");
    step(1);
    rst_n        = 1'b1;
    bus.PWM_IN   = '0;
    bus.MAX_HIGH = '0;
    expect_at(1, K_STATE, sv(ST_ARM), "rstf_arm");
    expect_at(2, K_STATE, sv(ST_RUN), "rstf_run");
    step(2);

    // Reset mid-RUN kills the drive on the same edge
    bus.PWM_IN = bit_v(1);
    expect_at(1, K_XOUT, bit_v(1), "rstr_pre");
    step(1);
    rst_n = 1'b0;
    expect_at(1, K_XOUT,  '0,          "rstr_xout");
    expect_at(1, K_STATE, sv(ST_IDLE), "rstr_state");
    expect_at(1, K_FAULT, sv(0),       "rstr_fault");
    step(1);
    rst_n      = 1'b1;
    bus.PWM_IN = '0;
    expect_at(2, K_STATE, sv(ST_RUN), "rstr_run");
    step(2);

    // ENABLE drop in RUN: IDLE, drive off one cycle later
    bus.PWM_IN = bit_v(1);
    step(1);
    bus.ENABLE = 1'b0;
    expect_at(1, K_STATE, sv(ST_IDLE), "endrop_state");
    expect_at(1, K_XOUT,  bit_v(1),    "endrop_last");
    expect_at(2, K_XOUT,  '0,          "endrop_off");
    step(2);

    // Trip coinciding with ENABLE drop: FAULT wins
    bus.ENABLE = 1'b1;
    bus.PWM_IN = '0;
    expect_at(2, K_STATE, sv(ST_RUN), "race_run");
    step(2);
    bus.MAX_HIGH = CW'(5);
    bus.PWM_IN   = bit_v(2);
    expect_at(5, K_STATE, sv(ST_RUN), "race_pre");
    step(5);
    bus.ENABLE = 1'b0;
    expect_at(1, K_STATE, sv(ST_FAULT), "race_state");
    expect_at(1, K_CH,    sv(2),        "race_idx");
    expect_at(1, K_FAULT, sv(1),        "race_fault");
    step(3);

    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation never checked", exp_q[i].name);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xdcr_out_guard.md
XDCR_OUT_GUARD -- requirements
Module: xdcr_out_guard

Interface
REQ-001 Parameter TRANS_NUM, default 249, number of transducer channels.
REQ-002 Parameter CNT_WIDTH, default 16, width of per-channel high-time counter and MAX_HIGH.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 CLK  input  1  PWM clock, same domain as the pwm stage output.
REQ-005 RESET_N  input  1  synchronous active-low reset.
REQ-006 ENABLE  input  1  global output enable from controller.
REQ-007 MAX_HIGH  input  CNT_WIDTH  max consecutive high cycles per channel; 0 disables watchdog.
REQ-008 FAULT_CLR  input  1  single-cycle fault clear request.
REQ-009 PWM_IN  input  TRANS_NUM  per-channel PWM from pwm stage.
REQ-010 XDCR_OUT  output  TRANS_NUM  gated, registered drive to transducers.
REQ-011 FAULT  output  1  latched fault flag.
REQ-012 FAULT_CH  output  8  index of tripping channel.
REQ-013 FAULT_PULSE  output  1  one-cycle strobe on fault entry.
REQ-014 STATE  output  2  current state encoding for GPIO/debug.

Function
REQ-015 States SHALL be IDLE=0, ARM=1, RUN=2, FAULT=3.
REQ-016 IDLE -> ARM when ENABLE=1; ARM -> RUN after one cycle with all PWM_IN low; any state except FAULT -> IDLE when ENABLE=0.
REQ-017 RUN -> FAULT when any channel counter equals MAX_HIGH with MAX_HIGH!=0 and PWM_IN still high.
REQ-018 FAULT -> ARM on FAULT_CLR if ENABLE=1, else -> IDLE; ENABLE alone SHALL NOT leave FAULT.
REQ-019 XDCR_OUT[i] SHALL be registered PWM_IN[i] AND (state==RUN): 1-cycle latency, forced 0 in every other state the cycle after leaving RUN.
REQ-020 Per-channel counter: clear when PWM_IN[i]=0, increment when 1, saturate at all-ones; counters run in all states.
REQ-021 ARM exists so no truncated first pulse is emitted: output passes only from a PWM low phase.
REQ-022 FAULT_CH SHALL hold the lowest index among channels tripping in the fault-entry cycle; held until cleared.
REQ-023 FAULT_PULSE SHALL be high exactly one cycle, coincident with FAULT rising.
REQ-024 Trip and FAULT_CLR in the same cycle: trip wins, state FAULT, FAULT_CH updated.
REQ-025 Trip and ENABLE falling in the same RUN cycle: FAULT wins.
REQ-026 MAX_HIGH changed during RUN SHALL take effect the next cycle; no re-arm.

Reset
REQ-027 On RESET_N=0 at CLK edge: state IDLE, XDCR_OUT all 0, FAULT 0, FAULT_CH 0, FAULT_PULSE 0, counters 0.
REQ-028 Reset mid-RUN or mid-FAULT SHALL force outputs 0 on the same edge and discard the latched fault.

Structure
REQ-029 Shared package SHALL hold the state enum and the 8-bit FAULT_CH width constant.
REQ-030 One sub-module xdcr_high_watchdog (per-channel counter + trip compare) SHALL be instantiated TRANS_NUM times via generate.
REQ-031 Lowest-index trip encoder and FSM SHALL live in xdcr_out_guard.

Verification
REQ-032 ENABLE=1, PWM_IN[0] high at enable, MAX_HIGH=0 -> state ARM until PWM_IN all low, RUN next cycle, XDCR_OUT[0] follows PWM_IN[0] with 1-cycle delay.
REQ-033 RUN, MAX_HIGH=100, PWM_IN[5] held high 100 cycles -> FAULT=1, FAULT_CH=5, FAULT_PULSE one cycle, XDCR_OUT all 0 next cycle.
REQ-034 RUN, channels 7 and 200 hit MAX_HIGH same cycle -> FAULT_CH=7.
REQ-035 FAULT, FAULT_CLR coincident with a new trip on ch 3 -> stays FAULT, FAULT_CH=3; later FAULT_CLR with ENABLE=1 -> ARM.
REQ-036 RUN, RESET_N=0 one cycle -> XDCR_OUT=0, state IDLE, FAULT=0; ENABLE drop in RUN -> IDLE, outputs 0 next cycle.
